cr_kme_fifo_serializer: RTL and testbench

Downstream consumer of the KME 71-bit entry FIFO. It pops one entry at a time from the FIFO read port, using the FIFO's valid/ack pop convention, and emits it as one or two 32-bit beats on a valid/ready output stream toward the key-op datapath. It tracks packet framing and counts completed packets. It also flags tag inconsistencies inside a packet.

---
 rtl/cr_kme_fifo_serializer.sv | 134 +++++++++++++
 tb/tb_cr_kme_fifo_serializer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_kme_fifo_serializer.sv
// Pops 71-bit KME entries from the entry FIFO and emits them as one or two
// 32-bit beats on a valid/ready stream. Tracks packet framing, counts
// completed packets and flags tag changes inside a packet.
module cr_kme_fifo_serializer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [70:0]      in_data,
    input  logic             in_valid,
    output logic             in_ack,
    output logic [31:0]      out_data,
    output logic [4:0]       out_tag,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             tag_err,
    output logic             busy
);

    localparam int unsigned ENT_W = 71;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned EOP_B = 70;
    localparam int unsigned HLF_B = 69;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [ENT_W-1:0]   hold_q,    hold_d;
    logic               in_pkt_q,  in_pkt_d;
    logic [TAG_W-1:0]   pkt_tag_q, pkt_tag_d;
    logic               tag_err_q, tag_err_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic               held_eop;
    logic               held_half;
    logic [TAG_W-1:0]   held_tag;
    logic               last_beat;
    logic               handshake;

    assign held_eop  = hold_q[EOP_B];
    assign held_half = hold_q[HLF_B];
    assign held_tag  = hold_q[68:64];

    // Output decode from the held entry and beat position
    always_comb begin
        out_valid = (state_q != ST_IDLE);
        out_data  = (state_q == ST_HI) ? hold_q[63:32] : hold_q[31:0];
        out_tag   = held_tag;
        last_beat = (state_q == ST_HI) || ((state_q == ST_LO) && held_half);
        out_last  = held_eop && last_beat;
        handshake = out_valid && out_ready;
        in_ack    = in_valid && !rst && ((state_q == ST_IDLE) || (handshake && last_beat));
        busy      = (state_q != ST_IDLE) || in_pkt_q;
        pkt_cnt   = pkt_cnt_q;
        tag_err   = tag_err_q;
    end

    // Next-state: beat sequencing, entry load, packet tracking, counter
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        in_pkt_d  = in_pkt_q;
        pkt_tag_d = pkt_tag_q;
        tag_err_d = tag_err_q;
        pkt_cnt_d = pkt_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_ack) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (handshake) begin
                    if (!held_half) begin
                        state_d = ST_HI;
                    end else if (in_ack) begin
                        state_d = ST_LO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HI: begin
                if (handshake) begin
                    state_d = in_ack ? ST_LO : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (in_ack) begin
            hold_d = in_data;
            if (!in_pkt_q) begin
                pkt_tag_d = in_data[68:64];
            end else if (in_data[68:64] != pkt_tag_q) begin
                tag_err_d = 1'b1;
            end
            in_pkt_d = !in_data[EOP_B];
        end

        if (handshake && out_last && (pkt_cnt_q != {CNT_W{1'b1}})) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            in_pkt_q  <= 1'b0;
            pkt_tag_q <= '0;
            tag_err_q <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            in_pkt_q  <= in_pkt_d;
            pkt_tag_q <= pkt_tag_d;
            tag_err_q <= tag_err_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_cr_kme_fifo_serializer.sv
// Self-checking bench: a FIFO queue feeds the serializer and a beat-queue
// reference model predicts every output each cycle.
module tb_cr_kme_fifo_serializer;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [70:0]      in_data;
    logic             in_valid;
    logic             in_ack;
    logic [31:0]      out_data;
    logic [4:0]       out_tag;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] pkt_cnt;
    logic             tag_err;
    logic             busy;

    always #5 clk = ~clk;

    cr_kme_fifo_serializer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ack    (in_ack),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pkt_cnt   (pkt_cnt),
        .tag_err   (tag_err),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
        logic        l;
    } beat_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [70:0] fifo_q[$];
    beat_t       m_beats[$];
    logic        m_in_pkt;
    logic [4:0]  m_pkt_tag;
    logic        m_tag_err;
    int          m_cnt;

    logic        s_ack, s_valid, s_last, s_err, s_busy;
    logic [31:0] s_data;
    logic [4:0]  s_tag;
    logic [CNT_W-1:0] s_cnt;

    // Single comparison point for the whole bench
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [70:0] mk(input bit eop, input bit half,
                                       input logic [4:0] tag, input logic [63:0] d);
        return {eop, half, tag, d};
    endfunction

    task automatic model_reset();
        m_beats.delete();
        m_in_pkt  = 1'b0;
        m_pkt_tag = '0;
        m_tag_err = 1'b0;
        m_cnt     = 0;
    endtask

    // One clock: drive at negedge, check against the model, advance the model
    task automatic step(input bit rdy, input bit gate, input bit r);
        logic  exp_ack;
        beat_t b;
        logic [70:0] e;
        @(negedge clk);
        rst       = r;
        out_ready = rdy;
        in_valid  = gate && (fifo_q.size() != 0);
        in_data   = in_valid ? fifo_q[0] : 71'({$urandom(), $urandom(), $urandom()});
        #1;
        s_ack = in_ack; s_valid = out_valid; s_last = out_last; s_data = out_data;
        s_tag = out_tag; s_cnt = pkt_cnt; s_err = tag_err; s_busy = busy;

        exp_ack = in_valid && !r && ((m_beats.size() == 0) || (rdy && m_beats.size() == 1));
        chk("in_ack", 64'(in_ack), 64'(exp_ack));
        chk("out_valid", 64'(out_valid), 64'(m_beats.size() != 0));
        if (m_beats.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(m_beats[0].d));
            chk("out_tag",  64'(out_tag),  64'(m_beats[0].t));
            chk("out_last", 64'(out_last), 64'(m_beats[0].l));
        end
        chk("busy", 64'(busy), 64'((m_beats.size() != 0) || m_in_pkt));
        chk("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
        chk("tag_err", 64'(tag_err), 64'(m_tag_err));

        if (r) begin
            model_reset();
        end else begin
            if (rdy && m_beats.size() != 0) begin
                b = m_beats.pop_front();
                if (b.l && m_cnt < CNT_MAX) m_cnt++;
            end
            if (exp_ack) begin
                e = fifo_q.pop_front();
                b.d = e[31:0]; b.t = e[68:64]; b.l = e[70] && e[69];
                m_beats.push_back(b);
                if (!e[69]) begin
                    b.d = e[63:32]; b.l = e[70];
                    m_beats.push_back(b);
                end
                if (!m_in_pkt) m_pkt_tag = e[68:64];
                else if (e[68:64] != m_pkt_tag) m_tag_err = 1'b1;
                m_in_pkt = !e[70];
            end
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((fifo_q.size() != 0 || m_beats.size() != 0) && k < 300) begin
            step(1'b1, 1'b1, 1'b0);
            k++;
        end
        if (k >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d cycles, fifo=%0d beats=%0d", k, fifo_q.size(), m_beats.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state
        step(1'b0, 1'b0, 1'b0);
        chk("rst_out_data", 64'(s_data), 64'h0);
        chk("rst_out_tag",  64'(s_tag),  64'h0);
        chk("rst_out_last", 64'(s_last), 64'h0);
        chk("rst_busy",     64'(s_busy), 64'h0);

        // Single full entry
        fifo_q.push_back(mk(1, 0, 5'd3, 64'h1122334455667788));
        step(1, 1, 0);
        chk("t1_ack", 64'(s_ack), 64'h1);
        step(1, 1, 0);
        chk("t1_beat0", 64'(s_data), 64'h55667788);
        chk("t1_last0", 64'(s_last), 64'h0);
        chk("t1_ack_once", 64'(s_ack), 64'h0);
        step(1, 1, 0);
        chk("t1_beat1", 64'(s_data), 64'h11223344);
        chk("t1_last1", 64'(s_last), 64'h1);
        step(1, 1, 0);
        chk("t1_cnt", 64'(s_cnt), 64'h1);

        // Four back-to-back half entries
        for (int i = 0; i < 4; i++)
            fifo_q.push_back(mk(i == 3, 1, 5'd5, 64'(64'hA0 + i)));
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0);
            if (i < 4) acks += int'(s_ack);
            else       chk("t2_ack_end", 64'(s_ack), 64'h0);
            if (i >= 1) begin
                chk("t2_valid", 64'(s_valid), 64'h1);
                chk("t2_last",  64'(s_last),  64'(i == 4));
            end
        end
        chk("t2_ack_count", 64'(acks), 64'd4);
        step(1, 1, 0);
        chk("t2_cnt", 64'(s_cnt), 64'h2);

        // Backpressure in HI
        fifo_q.push_back(mk(1, 0, 5'd2, 64'hDEADBEEF_0BADF00D));
        fifo_q.push_back(mk(1, 1, 5'd2, 64'h0000_0000_1234_5678));
        step(1, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0);
            chk("t3_stall_ack",  64'(s_ack),   64'h0);
            chk("t3_stall_data", 64'(s_data),  64'hDEADBEEF);
            chk("t3_stall_vld",  64'(s_valid), 64'h1);
        end
        step(1, 1, 0);
        chk("t3_resume_ack", 64'(s_ack), 64'h1);
        drain();

        // Tag mismatch inside a packet
        fifo_q.push_back(mk(0, 1, 5'd1, 64'h11));
        fifo_q.push_back(mk(1, 1, 5'd2, 64'h22));
        drain();
        step(1, 0, 0);
        chk("t4_err_set", 64'(s_err), 64'h1);
        fifo_q.push_back(mk(1, 1, 5'd7, 64'h33));
        drain();
        step(1, 0, 0);
        chk("t4_err_sticky", 64'(s_err), 64'h1);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("t4_err_clear", 64'(s_err), 64'h0);

        // Reset mid-packet
        fifo_q.push_back(mk(0, 0, 5'd4, 64'hCAFEF00D_87654321));
        fifo_q.push_back(mk(1, 0, 5'd4, 64'h01020304_05060708));
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 1);
        chk("t5_ack_in_rst", 64'(s_ack), 64'h0);
        step(0, 0, 0);
        chk("t5_valid", 64'(s_valid), 64'h0);
        chk("t5_busy",  64'(s_busy),  64'h0);
        chk("t5_cnt",   64'(s_cnt),   64'h0);
        drain();
        step(1, 0, 0);
        chk("t5_cnt_after", 64'(s_cnt), 64'h1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            if (fifo_q.size() < 3 && $urandom_range(0, 3) != 0)
                fifo_q.push_back(mk($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
                                    5'($urandom_range(0, 3)), {$urandom(), $urandom()}));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 299) == 0);
        end
        drain();

        // Counter saturation
        step(0, 0, 1);
        for (int i = 0; i < 17; i++)
            fifo_q.push_back(mk(1, 1, 5'd6, 64'(i)));
        drain();
        step(1, 0, 0);
        chk("t7_sat", 64'(s_cnt), 64'd15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
